// File: rtl/count_step_monitor_pkg.sv
// Shared types and helpers for the count_step_monitor slice.
package count_step_monitor_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam int unsigned CALC_W = 32;

    // value + 1 wrapped to 'width' bits; callers narrow the result with an explicit cast
    function automatic logic [CALC_W-1:0] next_count(input logic [CALC_W-1:0] value,
                                                     input int unsigned        width);
        logic [CALC_W-1:0] mask;
        mask = (CALC_W'(1) << width) - CALC_W'(1);
        return (value + CALC_W'(1)) & mask;
    endfunction

endpackage

// File: rtl/count_step_monitor_if.sv
// Sample/clear inputs and health outputs of the counter step monitor.
interface count_step_monitor_if #(
    parameter int unsigned W       = 2,
    parameter int unsigned WRAPS_W = 4
);
    logic               in_valid;
    logic [W-1:0]       in_count;
    logic               clr;
    logic               wrap_pulse;
    logic [WRAPS_W-1:0] wrap_count;
    logic               step_err;
    logic               fault;
    logic [W-1:0]       fault_prev;
    logic [W-1:0]       fault_value;
    logic               tracking;

    modport master (
        output in_valid, in_count, clr,
        input  wrap_pulse, wrap_count, step_err, fault, fault_prev, fault_value, tracking
    );

    modport slave (
        input  in_valid, in_count, clr,
        output wrap_pulse, wrap_count, step_err, fault, fault_prev, fault_value, tracking
    );
endinterface

// File: rtl/count_step_monitor_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of rolling over.
module sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != '1))
            count_d = count_q + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/count_step_monitor.sv
// Checks that an upstream counter only holds or steps by +1, counts wraps, latches faults.
// Define COUNT_STEP_MONITOR_ASSERT_EN to compile in the concurrent health assertions.
module count_step_monitor
    import count_step_monitor_pkg::*;
#(
    parameter int unsigned W       = 2,
    parameter int unsigned WRAPS_W = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    count_step_monitor_if.slave  bus
);
    localparam logic [1:0] S_EMPTY = ST_EMPTY;
    localparam logic [1:0] S_TRACK = ST_TRACK;
    localparam logic [1:0] S_FAULT = ST_FAULT;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] prev_q, prev_d;
    logic [W-1:0] fault_prev_q, fault_prev_d;
    logic [W-1:0] fault_value_q, fault_value_d;
    logic         wrap_pulse_q, wrap_pulse_d;
    logic         step_err_q, step_err_d;
    logic         fault_q, fault_d;
    logic         tracking_q, tracking_d;
    logic         wrap_inc_c;
    logic [W-1:0] exp_c;

    assign exp_c = W'(next_count(CALC_W'(prev_q), W));

    // Next-state and capture logic; clr always wins over a same-cycle sample.
    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        fault_prev_d  = fault_prev_q;
        fault_value_d = fault_value_q;
        wrap_pulse_d  = 1'b0;
        step_err_d    = 1'b0;
        wrap_inc_c    = 1'b0;

        case (state_q)
            S_EMPTY: begin
                if (bus.clr) begin
                    prev_d = '0;
                end else if (bus.in_valid) begin
                    prev_d  = bus.in_count;
                    state_d = S_TRACK;
                end
            end
            S_TRACK: begin
                if (bus.clr) begin
                    prev_d  = '0;
                    state_d = S_EMPTY;
                end else if (bus.in_valid) begin
                    if (bus.in_count == exp_c) begin
                        prev_d = bus.in_count;
                        if (prev_q == '1) begin
                            wrap_pulse_d = 1'b1;
                            wrap_inc_c   = 1'b1;
                        end
                    end else if (bus.in_count != prev_q) begin
                        step_err_d    = 1'b1;
                        fault_prev_d  = prev_q;
                        fault_value_d = bus.in_count;
                        state_d       = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                if (bus.clr) begin
                    prev_d        = '0;
                    fault_prev_d  = '0;
                    fault_value_d = '0;
                    state_d       = S_EMPTY;
                end
            end
            default: begin
                prev_d  = '0;
                state_d = S_EMPTY;
            end
        endcase

        fault_d    = (state_d == S_FAULT);
        tracking_d = (state_d == S_TRACK);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_EMPTY;
            prev_q        <= '0;
            fault_prev_q  <= '0;
            fault_value_q <= '0;
            wrap_pulse_q  <= 1'b0;
            step_err_q    <= 1'b0;
            fault_q       <= 1'b0;
            tracking_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            fault_prev_q  <= fault_prev_d;
            fault_value_q <= fault_value_d;
            wrap_pulse_q  <= wrap_pulse_d;
            step_err_q    <= step_err_d;
            fault_q       <= fault_d;
            tracking_q    <= tracking_d;
        end
    end

    // Wrap counter survives clr; only reset clears it.
    sat_counter #(.WIDTH(WRAPS_W)) u_wrap_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (1'b0),
        .inc   (wrap_inc_c),
        .count (bus.wrap_count)
    );

    assign bus.wrap_pulse  = wrap_pulse_q;
    assign bus.step_err    = step_err_q;
    assign bus.fault       = fault_q;
    assign bus.fault_prev  = fault_prev_q;
    assign bus.fault_value = fault_value_q;
    assign bus.tracking    = tracking_q;

`ifdef COUNT_STEP_MONITOR_ASSERT_EN
    a_no_dual_pulse: assert property (@(posedge clk) disable iff (!rstn)
        !(wrap_pulse_q && step_err_q));

    a_fault_sticky: assert property (@(posedge clk) disable iff (!rstn)
        (fault_q && !bus.clr) |=> fault_q);

    a_wrap_sat: assert property (@(posedge clk) disable iff (!rstn)
        1'b1 |=> (bus.wrap_count >= $past(bus.wrap_count)));

    // A wrap lands prev on zero, which the first disjunct already admits.
    a_track_mono: assert property (@(posedge clk) disable iff (!rstn)
        (tracking_q && $past(tracking_q)) |-> ((prev_q == '0) || (prev_q >= $past(prev_q))));
`endif

endmodule

// File: tb/tb_count_step_monitor.sv
// Randomized + directed bench for count_step_monitor against a behavioural reference.
module tb_count_step_monitor;
    localparam int unsigned W   = 2;
    localparam int unsigned MOD = 1 << W;

    logic clk;
    logic rstn;
    int   n_total;
    int   n_bad;

    count_step_monitor_if #(.W(W), .WRAPS_W(4)) bus_a ();
    count_step_monitor_if #(.W(W), .WRAPS_W(2)) bus_b ();

    count_step_monitor #(.W(W), .WRAPS_W(4)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a.slave));
    count_step_monitor #(.W(W), .WRAPS_W(2)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = no reference, 1 = following, 2 = latched fault.
    int m_mode, m_prev, m_wraps, m_fprev, m_fval, m_wp, m_se;

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_wraps = 0; m_fprev = 0; m_fval = 0; m_wp = 0; m_se = 0;
    endtask

    task automatic model_step(input int v, input int c, input int cl);
        m_wp = 0;
        m_se = 0;
        if (cl != 0) begin
            if (m_mode == 2) begin
                m_fprev = 0;
                m_fval  = 0;
            end
            m_mode = 0;
            m_prev = 0;
        end else if (v != 0) begin
            if (m_mode == 0) begin
                m_prev = c;
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (c == (m_prev + 1) % MOD) begin
                    if (m_prev == MOD - 1) begin
                        m_wp = 1;
                        m_wraps++;
                    end
                    m_prev = c;
                end else if (c != m_prev) begin
                    m_se    = 1;
                    m_fprev = m_prev;
                    m_fval  = c;
                    m_mode  = 2;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string ctx);
        chk({ctx, ".a.wrap_pulse"},  32'(bus_a.wrap_pulse),  32'(m_wp));
        chk({ctx, ".a.step_err"},    32'(bus_a.step_err),    32'(m_se));
        chk({ctx, ".a.fault"},       32'(bus_a.fault),       32'(m_mode == 2));
        chk({ctx, ".a.tracking"},    32'(bus_a.tracking),    32'(m_mode == 1));
        chk({ctx, ".a.fault_prev"},  32'(bus_a.fault_prev),  32'(m_fprev));
        chk({ctx, ".a.fault_value"}, 32'(bus_a.fault_value), 32'(m_fval));
        chk({ctx, ".a.wrap_count"},  32'(bus_a.wrap_count),  32'((m_wraps > 15) ? 15 : m_wraps));
        chk({ctx, ".b.wrap_pulse"},  32'(bus_b.wrap_pulse),  32'(m_wp));
        chk({ctx, ".b.step_err"},    32'(bus_b.step_err),    32'(m_se));
        chk({ctx, ".b.fault"},       32'(bus_b.fault),       32'(m_mode == 2));
        chk({ctx, ".b.wrap_count"},  32'(bus_b.wrap_count),  32'((m_wraps > 3) ? 3 : m_wraps));
    endtask

    task automatic set_in(input int v, input int c, input int cl);
        bus_a.in_valid = 1'(v); bus_a.in_count = W'(c); bus_a.clr = 1'(cl);
        bus_b.in_valid = 1'(v); bus_b.in_count = W'(c); bus_b.clr = 1'(cl);
    endtask

    // Apply one sample, clock it, then compare one time unit after the edge.
    task automatic step(input string ctx, input int v, input int c, input int cl);
        set_in(v, c, cl);
        model_step(v, c, cl);
        @(posedge clk);
        #1;
        chk_all(ctx);
    endtask

    initial begin
        int k, r, v, c, cl;
        n_total = 0;
        n_bad   = 0;
        rstn    = 1'b0;
        set_in(0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        #2 rstn = 1'b1;

        // Count 0..3 then wrap to 0
        for (int i = 0; i < 5; i++) step("seq", 1, i % MOD, 0);
        chk("seq.wraps_seen", 32'(bus_a.wrap_count), 32'd1);

        // Holds are legal
        step("hold", 1, 1, 0);
        step("hold", 1, 1, 0);
        step("hold", 1, 1, 0);
        step("hold", 1, 2, 0);
        step("idle", 0, 3, 0);
        chk("hold.tracking", 32'(bus_a.tracking), 32'd1);

        // Reseed on 1, illegal jump to 3, then sampling is ignored
        step("clr_track", 0, 0, 1);
        step("seed1", 1, 1, 0);
        step("jump", 1, 3, 0);
        chk("jump.fault_prev",  32'(bus_a.fault_prev),  32'd1);
        chk("jump.fault_value", 32'(bus_a.fault_value), 32'd3);
        for (int i = 0; i < 4; i++) step("ignored", 1, i, 0);

        // clr beats same-cycle sample; next sample reseeds
        step("clr_fault", 1, 2, 1);
        step("seed2", 1, 2, 0);
        step("after_seed", 1, 3, 0);
        step("after_seed", 1, 0, 0);

        // Many wraps: 2-bit counter saturates, 4-bit one keeps going up to 15
        for (int i = 0; i < 80; i++) step("many_wraps", 1, (i + 1) % MOD, 0);
        chk("many_wraps.b_sat", 32'(bus_b.wrap_count), 32'd3);

        // Asynchronous reset between edges
        step("pre_rst", 1, 2, 0);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst");
        set_in(0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("in_rst");
        #2 rstn = 1'b1;
        step("restart", 1, 3, 0);
        step("restart", 1, 0, 0);
        step("restart", 1, 1, 0);

        // Randomized: mostly legal steps and holds, occasional jumps, clears and idles
        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 99));
            cl = (r < 5) ? 1 : 0;
            v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            k  = int'($urandom_range(0, 9));
            if (k < 6)      c = (m_prev + 1) % MOD;
            else if (k < 8) c = m_prev;
            else            c = int'($urandom_range(0, MOD - 1));
            step("rand", v, c, cl);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/count_step_monitor.md
Name: count_step_monitor

Overview:
- Downstream consumer of the free-running 2-bit counter stage. Samples the counter value each valid cycle and checks that it only holds or steps by +1 modulo 2^W.
- Reports wraps (max -> 0) and the number of wraps seen.
- Latches the first illegal step in a sticky fault state until cleared.
- Gives the formal flow a registered, property-friendly view of counter health.

Parameters:
- W, 2, width of the monitored count value.
- WRAPS_W, 4, width of the saturating wrap counter.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  in_count is meaningful this cycle.
- in_count  input  W  counter value from upstream stage.
- clr  input  1  synchronous fault clear / resync request.
- wrap_pulse  output  1  one-cycle pulse: a legal wrap was accepted.
- wrap_count  output  WRAPS_W  saturating number of accepted wraps.
- step_err  output  1  one-cycle pulse: illegal step detected.
- fault  output  1  sticky; high while in ST_FAULT.
- fault_prev  output  W  last good value before the illegal step.
- fault_value  output  W  offending value.
- tracking  output  1  high while in ST_TRACK.

Behaviour:
- One clock domain; all state on posedge clk. Asynchronous clear on rstn low, independent of clk.
- Reset values:
  - state = ST_EMPTY; prev = 0.
  - wrap_pulse = step_err = fault = tracking = 0.
  - wrap_count = fault_prev = fault_value = 0.
- All outputs are registered. Pulses appear the cycle after the sample edge (latency 1).
- ST_EMPTY (no reference value):
  - in_valid: prev <= in_count; go to ST_TRACK.
  - No pulses are generated.
- ST_TRACK, on in_valid, with exp = prev + 1 mod 2^W (W-bit wrap, no carry kept):
  - in_count == exp: prev <= in_count. If prev == all-ones, assert wrap_pulse and increment wrap_count, saturating at 2^WRAPS_W-1 (no rollover).
  - in_count == prev: hold is legal; no change, no pulse.
  - Otherwise: assert step_err; fault_prev <= prev; fault_value <= in_count; go to ST_FAULT.
- ST_FAULT:
  - fault = 1; in_valid is ignored; fault_prev and fault_value are frozen.
  - On clr: go to ST_EMPTY; fault, fault_prev and fault_value return to 0.
  - wrap_count is not cleared by clr.
- clr in ST_TRACK or ST_EMPTY: go to ST_EMPTY; prev <= 0.
- Priority and idle cases:
  - clr and in_valid in the same cycle: clr wins and the sample is discarded.
  - in_valid low: state and prev hold; pulses deassert.
- tracking = (state == ST_TRACK), registered with the state.
- Reset asserted mid-operation: every register returns to its reset value immediately. The first valid sample after release re-seeds prev.

Optional Feature:
- Macro: COUNT_STEP_MONITOR_ASSERT_EN.
- Defined: compile in concurrent assertions, all disabled while rstn is low:
  - a_no_dual_pulse: wrap_pulse and step_err are never high in the same cycle.
  - a_fault_sticky: fault stays high until the cycle after clr.
  - a_wrap_sat: wrap_count never decreases.
  - a_track_mono: in ST_TRACK, prev == 0 or prev >= previous prev, except immediately after a wrap.
- Not defined: no assertions and no extra logic. Ports and behaviour are identical.

Decomposition:
- Package count_step_monitor_pkg holds:
  - enum state_e {ST_EMPTY, ST_TRACK, ST_FAULT}, 2 bits.
  - A parameterised function next_count(value) returning value + 1 mod 2^W.
- Sub-module sat_counter (parameter WIDTH) for wrap_count.
  - Ports: clk, rstn, clr (unused here, tied 0), inc, count.
  - Saturates at all-ones.
- FSM and capture registers stay in the top module.

Test Plan:
- Reset, then in_valid = 1 with in_count 0,1,2,3,0 -> tracking high from cycle 2; wrap_pulse exactly once (after the 3 -> 0 sample); wrap_count = 1; fault = 0.
- In ST_TRACK, in_count 1,1,1,2 -> no pulses; prev = 2; still tracking.
- In ST_TRACK, in_count 1 then 3 -> step_err pulse; fault = 1; fault_prev = 1; fault_value = 3; further in_valid has no effect.
- In fault, clr = 1 with in_valid = 1 and in_count = 2 -> state ST_EMPTY; fault = 0; sample discarded. The next sample 2 seeds prev = 2.
- With WRAPS_W = 2, drive 20 consecutive 0..3 sequences -> wrap_count reaches 3 and stays at 3; wrap_pulse still fires on every wrap.
- Drop rstn asynchronously mid-sequence between clock edges -> all outputs read 0 before the next clk edge; the sequence restarts cleanly after release.
